// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter: round-robin with bounded lock, combinational
// memory drive, and a registered one-cycle response per accepted access.
module dmem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_LOCK   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic [DATA_WIDTH-1:0] m0_addr,
    input  logic [2:0]            m0_ctrl,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    input  logic                  m0_lock,
    output logic                  m0_gnt,
    output logic                  m0_rvalid,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    output logic                  m0_err,
    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic [DATA_WIDTH-1:0] m1_addr,
    input  logic [2:0]            m1_ctrl,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    input  logic                  m1_lock,
    output logic                  m1_gnt,
    output logic                  m1_rvalid,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic                  m1_err,
    output logic [DATA_WIDTH-1:0] mem_A,
    output logic                  mem_WE,
    output logic [2:0]            mem_AddressingControl,
    output logic [DATA_WIDTH-1:0] mem_WD,
    input  logic [DATA_WIDTH-1:0] mem_RD
);
    localparam int CNT_W = (MAX_LOCK > 0) ? $clog2(MAX_LOCK + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LOCK);

    // Misaligned, reserved-size, or beyond the 128 KiB window.
    function automatic logic access_err(input logic [DATA_WIDTH-1:0] addr,
                                        input logic [2:0] ctrl);
        logic e;
        e = (ctrl[1:0] == 2'b11)
            || (ctrl[1:0] == 2'b01 && addr[0])
            || (ctrl[1:0] == 2'b10 && addr[1:0] != 2'b00)
            || ((addr >> 17) != '0);
        return e;
    endfunction

    logic             last_gnt;
    logic             lock_prev;
    logic [CNT_W-1:0] lock_cnt;
    logic [CNT_W-1:0] lock_cnt_d;
    logic             gnt_any;
    logic             gnt_sel;
    logic             lock_eff;
    logic             other_req;

    logic [DATA_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic [2:0]            sel_ctrl;
    logic                  sel_we;
    logic                  sel_lock;
    logic                  sel_err;
    logic [DATA_WIDTH-1:0] load_data;

    logic [1:0]            rvalid_p1;
    logic [1:0]            err_p1;
    logic [DATA_WIDTH-1:0] rdata0_p1;
    logic [DATA_WIDTH-1:0] rdata1_p1;

    always_comb begin
        gnt_any    = 1'b0;
        gnt_sel    = 1'b0;
        lock_cnt_d = '0;
        lock_eff   = lock_prev && (last_gnt ? m1_req : m0_req);
        other_req  = last_gnt ? m0_req : m1_req;
        if (!rst && (m0_req || m1_req)) begin
            gnt_any = 1'b1;
            if (lock_eff && (lock_cnt < CNT_MAX || !other_req)) begin
                gnt_sel    = last_gnt;
                lock_cnt_d = other_req ? lock_cnt + 1'b1 : lock_cnt;
            end else if (m0_req && m1_req) begin
                gnt_sel = ~last_gnt;
            end else begin
                gnt_sel = m1_req;
            end
        end
    end

    assign m0_gnt    = gnt_any && !gnt_sel;
    assign m1_gnt    = gnt_any && gnt_sel;
    assign sel_addr  = gnt_sel ? m1_addr  : m0_addr;
    assign sel_wdata = gnt_sel ? m1_wdata : m0_wdata;
    assign sel_ctrl  = gnt_sel ? m1_ctrl  : m0_ctrl;
    assign sel_we    = gnt_sel ? m1_we    : m0_we;
    assign sel_lock  = gnt_sel ? m1_lock  : m0_lock;
    assign sel_err   = access_err(sel_addr, sel_ctrl);

    assign mem_A                 = gnt_any ? sel_addr  : '0;
    assign mem_WD                = gnt_any ? sel_wdata : '0;
    assign mem_AddressingControl = gnt_any ? sel_ctrl  : 3'b000;
    assign mem_WE                = gnt_any && sel_we && !sel_err;
    assign load_data             = (sel_err || sel_we) ? '0 : mem_RD;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_gnt  <= 1'b1;
            lock_prev <= 1'b0;
            lock_cnt  <= '0;
        end else begin
            if (gnt_any) last_gnt <= gnt_sel;
            lock_prev <= gnt_any && sel_lock;
            lock_cnt  <= lock_cnt_d;
        end
    end

    // ---- p1: response stage, one cycle after the grant ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rvalid_p1 <= 2'b00;
            err_p1    <= 2'b00;
            rdata0_p1 <= '0;
            rdata1_p1 <= '0;
        end else begin
            rvalid_p1 <= {m1_gnt, m0_gnt};
            err_p1    <= {m1_gnt && sel_err, m0_gnt && sel_err};
            rdata0_p1 <= m0_gnt ? load_data : '0;
            rdata1_p1 <= m1_gnt ? load_data : '0;
        end
    end

    assign m0_rvalid = rvalid_p1[0];
    assign m1_rvalid = rvalid_p1[1];
    assign m0_err    = err_p1[0];
    assign m1_err    = err_p1[1];
    assign m0_rdata  = rdata0_p1;
    assign m1_rdata  = rdata1_p1;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios then random traffic, all checked
// against a behavioural arbitration/memory model.
module tb_dmem_arbiter;
    localparam int MAX_LOCK = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        r_req[2], r_we[2], r_lock[2];
    logic [31:0] r_addr[2], r_wdata[2];
    logic [2:0]  r_ctrl[2];

    logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic [31:0] mem_A, mem_WD, mem_RD;
    logic        mem_WE;
    logic [2:0]  mem_AddressingControl;

    dmem_arbiter #(.DATA_WIDTH(32), .MAX_LOCK(MAX_LOCK)) dut (
        .clk(clk), .rst(rst),
        .m0_req(r_req[0]), .m0_we(r_we[0]), .m0_addr(r_addr[0]), .m0_ctrl(r_ctrl[0]),
        .m0_wdata(r_wdata[0]), .m0_lock(r_lock[0]), .m0_gnt(m0_gnt),
        .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(r_req[1]), .m1_we(r_we[1]), .m1_addr(r_addr[1]), .m1_ctrl(r_ctrl[1]),
        .m1_wdata(r_wdata[1]), .m1_lock(r_lock[1]), .m1_gnt(m1_gnt),
        .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .mem_A(mem_A), .mem_WE(mem_WE), .mem_AddressingControl(mem_AddressingControl),
        .mem_WD(mem_WD), .mem_RD(mem_RD)
    );

    function automatic logic [7:0] seed(input int k);
        case (k)
            0: return 8'h78;
            1: return 8'h56;
            2: return 8'h34;
            3: return 8'h12;
            default: return 8'((k * 97 + 13) ^ (k >> 3));
        endcase
    endfunction

    function automatic logic [31:0] ext(input logic [2:0] c, input logic [7:0] b0, b1, b2, b3);
        case (c[1:0])
            2'b00:   return c[2] ? {24'h0, b0} : {{24{b0[7]}}, b0};
            2'b01:   return c[2] ? {16'h0, b1, b0} : {{16{b1[7]}}, b1, b0};
            default: return {b3, b2, b1, b0};
        endcase
    endfunction

    // Memory the DUT talks to: 4 KiB window, byte-addressed, little-endian.
    logic [7:0]  env_mem[4096];
    logic        init_done = 1'b0;
    logic [11:0] ra, wa;
    assign ra = mem_A[11:0];
    assign wa = mem_A[11:0];
    always_comb mem_RD = ext(mem_AddressingControl, env_mem[ra], env_mem[ra + 12'd1],
                             env_mem[ra + 12'd2], env_mem[ra + 12'd3]);
    always @(posedge clk) begin
        if (!init_done) begin
            for (int k = 0; k < 4096; k++) env_mem[k] <= seed(k);
            init_done <= 1'b1;
        end else if (mem_WE) begin
            env_mem[wa] <= mem_WD[7:0];
            if (mem_AddressingControl[1:0] != 2'b00) env_mem[wa + 12'd1] <= mem_WD[15:8];
            if (mem_AddressingControl[1:0] == 2'b10) begin
                env_mem[wa + 12'd2] <= mem_WD[23:16];
                env_mem[wa + 12'd3] <= mem_WD[31:24];
            end
        end
    end

    // Reference model state
    logic [7:0]  ref_mem[4096];
    logic        ev[2], ee[2];
    logic [31:0] ed[2];
    int last = 1, prev_w = -1, prev_lock = 0, streak = 0;
    int obs_g;
    logic obs_we;
    int total = 0, bad = 0;

    function automatic logic aerr(input logic [31:0] a, input logic [2:0] c);
        return (c[1:0] == 2'b11) || (c[1:0] == 2'b01 && a[0] == 1'b1)
            || (c[1:0] == 2'b10 && a[1:0] != 2'b00) || (a[31:17] != 15'd0);
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] c);
        logic [11:0] i;
        i = a[11:0];
        return ext(c, ref_mem[i], ref_mem[i + 12'd1], ref_mem[i + 12'd2], ref_mem[i + 12'd3]);
    endfunction

    function automatic void ref_store(input logic [31:0] a, input logic [2:0] c, input logic [31:0] d);
        int nb;
        logic [11:0] i;
        nb = (c[1:0] == 2'b00) ? 1 : (c[1:0] == 2'b01) ? 2 : 4;
        i = a[11:0];
        for (int k = 0; k < nb; k++) ref_mem[i + 12'(k)] = d[8*k +: 8];
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // One cycle: called just after a falling edge with inputs already driven.
    task automatic cyc();
        int w;
        logic locked, e;
        logic gv[2], gerr[2];
        logic [31:0] gd[2];
        #1;
        gv = '{m0_rvalid, m1_rvalid};
        gerr = '{m0_err, m1_err};
        gd = '{m0_rdata, m1_rdata};
        if (rst) begin
            ev = '{1'b0, 1'b0}; ee = '{1'b0, 1'b0}; ed = '{32'h0, 32'h0};
            last = 1; prev_w = -1; prev_lock = 0; streak = 0;
        end
        for (int n = 0; n < 2; n++) begin
            chk($sformatf("rvalid%0d", n), 32'(gv[n]), 32'(ev[n]));
            chk($sformatf("err%0d", n), 32'(gerr[n]), 32'(ee[n]));
            chk($sformatf("rdata%0d", n), gd[n], ed[n]);
        end
        w = -1;
        locked = 1'b0;
        if (!rst && (r_req[0] || r_req[1])) begin
            if (prev_w >= 0 && prev_lock != 0 && r_req[prev_w]
                && (streak < MAX_LOCK || !r_req[1 - prev_w])) begin
                w = prev_w;
                locked = 1'b1;
            end else if (r_req[0] && r_req[1]) w = 1 - last;
            else w = r_req[1] ? 1 : 0;
        end
        obs_g = m0_gnt ? (m1_gnt ? 2 : 0) : (m1_gnt ? 1 : -1);
        obs_we = mem_WE;
        chk("gnt0", 32'(m0_gnt), 32'(w == 0));
        chk("gnt1", 32'(m1_gnt), 32'(w == 1));
        ev = '{1'b0, 1'b0}; ee = '{1'b0, 1'b0}; ed = '{32'h0, 32'h0};
        if (w >= 0) begin
            e = aerr(r_addr[w], r_ctrl[w]);
            chk("mem_A", mem_A, r_addr[w]);
            chk("mem_ctl", 32'(mem_AddressingControl), 32'(r_ctrl[w]));
            chk("mem_WD", mem_WD, r_wdata[w]);
            chk("mem_WE", 32'(mem_WE), 32'(!e && r_we[w]));
            ev[w] = 1'b1;
            ee[w] = e;
            ed[w] = (e || r_we[w]) ? 32'h0 : ref_load(r_addr[w], r_ctrl[w]);
            if (!e && r_we[w]) ref_store(r_addr[w], r_ctrl[w], r_wdata[w]);
            streak = locked ? (r_req[1 - w] ? streak + 1 : streak) : 0;
            last = w;
            prev_lock = int'(r_lock[w]);
        end else begin
            chk("idle_A", mem_A, 32'h0);
            chk("idle_WE", 32'(mem_WE), 32'h0);
            chk("idle_WD", mem_WD, 32'h0);
            chk("idle_ctl", 32'(mem_AddressingControl), 32'h0);
            streak = 0;
            prev_lock = 0;
        end
        prev_w = w;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic setreq(input int n, input logic we, input logic [31:0] a,
                          input logic [2:0] c, input logic [31:0] d, input logic lk);
        r_req[n] = 1'b1; r_we[n] = we; r_addr[n] = a; r_ctrl[n] = c; r_wdata[n] = d; r_lock[n] = lk;
    endtask

    task automatic rand_req(input int n);
        int s;
        logic [1:0] sz;
        logic [31:0] a;
        s = $urandom_range(0, 9);
        sz = (s == 0) ? 2'b11 : 2'(s % 3);
        a = 32'($urandom_range(0, 255));
        if ($urandom_range(0, 9) < 7) a = a & ~((sz == 2'b10) ? 32'h3 : (sz == 2'b01) ? 32'h1 : 32'h0);
        if ($urandom_range(0, 19) == 0) a = a | 32'h20000;
        setreq(n, 1'($urandom_range(0, 1)), a, {1'($urandom_range(0, 1)), sz}, $urandom,
               $urandom_range(0, 9) < 3);
    endtask

    int seq[6];

    initial begin
        for (int k = 0; k < 4096; k++) ref_mem[k] = seed(k);
        for (int n = 0; n < 2; n++) setreq(n, 1'b0, 32'h0, 3'b010, 32'h0, 1'b0);
        r_req[0] = 1'b0; r_req[1] = 1'b0;
        @(negedge clk);
        cyc();
        cyc();
        rst = 1'b0;

        // Word load from address 0
        setreq(0, 1'b0, 32'h0, 3'b010, 32'h0, 1'b0);
        cyc();
        chk("ld_gnt", 32'(obs_g), 32'd0);
        r_req[0] = 1'b0;
        chk("ld_rvalid", 32'(m0_rvalid), 32'd1);
        chk("ld_rdata", m0_rdata, 32'h12345678);
        chk("ld_err", 32'(m0_err), 32'd0);
        cyc();

        // Misaligned half load
        setreq(0, 1'b0, 32'h21, 3'b001, 32'h0, 1'b0);
        cyc();
        chk("half_we", 32'(obs_we), 32'd0);
        r_req[0] = 1'b0;
        chk("half_err", 32'(m0_err), 32'd1);
        chk("half_rdata", m0_rdata, 32'h0);

        // Out-of-window word store (aliases to byte 0 in the 4 KiB model)
        setreq(1, 1'b1, 32'h20000, 3'b010, 32'hDEADBEEF, 1'b0);
        cyc();
        chk("oow_we", 32'(obs_we), 32'd0);
        r_req[1] = 1'b0;
        chk("oow_err", 32'(m1_err), 32'd1);
        chk("oow_mem", 32'(env_mem[0]), 32'h78);

        // Store byte then load it back zero-extended next cycle
        setreq(0, 1'b1, 32'h100, 3'b000, 32'h000000A5, 1'b0);
        cyc();
        r_req[0] = 1'b0;
        setreq(1, 1'b0, 32'h100, 3'b100, 32'h0, 1'b0);
        cyc();
        r_req[1] = 1'b0;
        chk("raw_rvalid", 32'(m1_rvalid), 32'd1);
        chk("raw_rdata", m1_rdata, 32'h000000A5);
        cyc();

        // Lock bound: m1 locks against a pending m0
        setreq(0, 1'b0, 32'h4, 3'b010, 32'h0, 1'b0);
        cyc();
        setreq(1, 1'b0, 32'h8, 3'b010, 32'h0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            cyc();
            seq[i] = obs_g;
        end
        for (int i = 0; i < 6; i++) chk($sformatf("lock_seq%0d", i), 32'(seq[i]), (i < 5) ? 32'd1 : 32'd0);
        chk("lock_cnt", 32'(dut.lock_cnt), 32'd0);
        r_req[0] = 1'b0; r_req[1] = 1'b0;
        cyc();

        // Reset mid-stream with both requesting, then round-robin from m0
        setreq(0, 1'b0, 32'h10, 3'b010, 32'h0, 1'b0);
        setreq(1, 1'b0, 32'h14, 3'b010, 32'h0, 1'b0);
        cyc();
        cyc();
        rst = 1'b1;
        cyc();
        chk("rst_gnt", 32'(obs_g), 32'hFFFFFFFF);
        chk("rst_rv", 32'({m0_rvalid, m1_rvalid}), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk($sformatf("rr_seq%0d", i), 32'(obs_g), 32'(i % 2));
            chk($sformatf("rr_rv%0d", i), 32'({m1_rvalid, m0_rvalid}), (i % 2 == 0) ? 32'd1 : 32'd2);
        end

        // Random traffic
        for (int c = 0; c < 400; c++) begin
            for (int n = 0; n < 2; n++) begin
                if (!r_req[n] || prev_w == n) begin
                    if ($urandom_range(0, 9) < 6) rand_req(n);
                    else r_req[n] = 1'b0;
                end else if ($urandom_range(0, 29) == 0) begin
                    r_req[n] = 1'b0;
                end
            end
            if (c == 200) rst = 1'b1;
            cyc();
            rst = 1'b0;
        end
        r_req[0] = 1'b0; r_req[1] = 1'b0;
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
